// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// The read register holds its value whenever re is low.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int CLEAR_ON_INIT = 0,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= din;
    if (re) r_rdata <= r_mem[raddr];
  end

  // Power-up clearing is left to the memory init flow; no logic is generated for it.
  if (CLEAR_ON_INIT != 0) begin : g_clear_on_init
  end

  if (ENABLE_BYPASS != 0) begin : g_bypass
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_bypass;
    // Same-cycle read/write to one address returns the freshly written word.
    always_ff @(posedge clk) begin
      if (re) begin
        r_din    <= din;
        r_bypass <= we && (waddr == raddr);
      end
    end
    assign dout = r_bypass ? r_din : r_rdata;
  end else begin : g_no_bypass
    assign dout = r_rdata;
  end
endmodule

// File: rtl/mor1kx_sync_fifo_sclk.sv
// First-word-fall-through FIFO controller around a bypassing simple dual-port RAM.
// The RAM output register doubles as the head register; head_v marks it valid.
module mor1kx_sync_fifo_sclk #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_head_v;
  logic                  w_clr, w_push, w_pop, w_re;

  assign w_clr  = rst | flush;
  assign w_push = wr_valid & wr_ready & ~w_clr;
  assign w_pop  = r_head_v & rd_ready & ~w_clr;
  // Refill the head whenever it is empty or being consumed and something is unread.
  assign w_re   = ~w_clr & ((r_wptr != r_rptr) | w_push) & (~r_head_v | w_pop);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_head_v <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_re) begin
        r_rptr   <= r_rptr + PTR_ONE;
        r_head_v <= 1'b1;
      end else if (w_pop) begin
        r_head_v <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .CLEAR_ON_INIT (0),
    .ENABLE_BYPASS (1)
  ) u_ram (
    .clk   (clk),
    .raddr (r_rptr),
    .re    (w_re),
    .waddr (r_wptr),
    .we    (w_push),
    .din   (wr_data),
    .dout  (rd_data)
  );

  assign count    = r_count;
  assign full     = (r_count == DEPTH);
  assign empty    = (r_count == '0);
  assign wr_ready = ~full;
  assign rd_valid = r_head_v;

  a_count_range: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH);
  a_head_stable: assert property (@(posedge clk) disable iff (rst | flush)
                   (rd_valid && !rd_ready) |=> $stable(rd_data));
endmodule

// File: doc/mor1kx_sync_fifo_sclk.md
Name: mor1kx_sync_fifo_sclk

Overview:
- Single-clock, first-word-fall-through FIFO controller.
- Drives the write-side and read-side port pair of a mor1kx_simple_dpram_sclk instance. This block generates waddr/we/din and raddr/re, and consumes dout.
- Presents valid/ready handshakes on both the producer and the consumer side.
- Intended as the generic buffer for store-buffer and bus-bridge queues in the pipeline.

Parameters:
- ADDR_WIDTH, 4, log2 of capacity; DEPTH = 1<<ADDR_WIDTH entries, minimum ADDR_WIDTH = 1.
- DATA_WIDTH, 32, entry width in bits.

Ports:
- clk  in  1  Clock. All logic is on the rising edge.
- rst  in  1  Reset. Synchronous, active-high.
- flush  in  1  Synchronous clear of FIFO state. Same effect as rst on all state and outputs.
- wr_data  in  DATA_WIDTH  Write data.
- wr_valid  in  1  Producer offers wr_data.
- wr_ready  out  1  FIFO can accept an entry; equals !full.
- rd_data  out  DATA_WIDTH  Head entry; meaningful only while rd_valid=1.
- rd_valid  out  1  Head entry present.
- rd_ready  in  1  Consumer accepts the head entry.
- count  out  ADDR_WIDTH+1  Entries accepted and not yet popped, range 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset and flush values: rd_valid=0, count=0, empty=1, full=0, wr_ready=1. Write and read pointers go to 0. RAM contents are not cleared. rd_data value is don't-care.
- rst or flush in cycle N: any push or pop offered in cycle N is discarded. State is clean in cycle N+1.
- Push: occurs when wr_valid & wr_ready at a clock edge. Sets we=1, waddr=wptr, din=wr_data. wptr increments modulo DEPTH.
- Pop: occurs when rd_valid & rd_ready at a clock edge.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full: wr_ready=0, so no push when full even if a pop occurs in the same cycle (no pass-through when full). wr_ready comes from registered count, with no combinational path from rd_ready.
- Empty: rd_valid=0, so no pop.
- Output stage: the RAM registered output is the head register. Internal flag head_v gives rd_valid=head_v.
- Read issue: re=1 when an unread entry exists (wptr!=rptr, or a push this cycle) AND (head_v==0 OR pop this cycle). Then raddr=rptr, rptr increments modulo DEPTH, and head_v<=1.
- Head clear: if there is a pop and no read issue, head_v<=0.
- When re=0, the RAM holds dout, so rd_data is stable while rd_valid & !rd_ready.
- Bypass: the RAM is instantiated with ENABLE_BYPASS=1 and CLEAR_ON_INIT=0. A read issued in the same cycle as the write to the same address returns the new data.
- Latency: write accepted into an empty FIFO in cycle N gives rd_valid=1 and rd_data=that word in cycle N+1.
- Back-to-back: with rd_ready held at 1 and a push every cycle, one pop per cycle occurs with 1-cycle latency and no bubbles.
- Pointer wrap: pointers are ADDR_WIDTH bits wide and wrap silently. Full and empty are derived only from count, never from pointer compare.
- Slot reuse: a RAM slot is reusable once its read is issued. This is safe because rd_data is held in the RAM output register until the next re. Logical capacity stays DEPTH via count.
- Protocol assertions (simulation only): wr_valid while !wr_ready is ignored, not an error. count must never exceed DEPTH. rd_data must be stable while rd_valid & !rd_ready.

Decomposition:
- No shared package is needed. DEPTH is a localparam.
- One sub-module: mor1kx_simple_dpram_sclk (ADDR_WIDTH, DATA_WIDTH, CLEAR_ON_INIT=0, ENABLE_BYPASS=1).
- Pointer/count control and head_v stay in this module.

Test Plan (ADDR_WIDTH=2, DEPTH=4, DATA_WIDTH=32):
- Reset: rst high 2 cycles -> rd_valid=0, count=0, empty=1, full=0, wr_ready=1.
- Single word: push 0xA5A5_0001 at cycle N -> rd_valid=1 and rd_data=0xA5A5_0001 at N+1. Pop at N+1 -> empty=1 at N+2.
- Fill: push 0x10,0x11,0x12,0x13 with rd_ready=0 -> full=1, wr_ready=0, count=4. A push of 0x14 is refused and count stays 4. Draining returns 0x10..0x13 in order, with rd_data stable while stalled.
- Streaming wrap: push 0..19 every cycle with rd_ready=1 -> pops 0..19 in order, one per cycle, count never above 1, pointers wrap 5 times.
- Full plus pop: at count=4, assert wr_valid and rd_ready together -> pop occurs, push is refused, count=3. Next cycle the push is accepted and count=3.
- Flush mid-stream: with count=3 assert flush -> next cycle count=0, rd_valid=0. Push 0x77 -> rd_data=0x77 one cycle later, with no stale words.
